alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Registered ID/EX operand-select stage for the 16-bit pipelined core; replaces the purely combinational operand mux at the ALU input.
- Resolves operand sources from register file, immediate and two forwarding paths (EX/MEM, MEM/WB), applies the source-select code and registers the ALU operands and store data for the EX stage.
- Supports pipeline stall and flush, and keeps a saturating forward-hit counter for performance debug.

Parameters:
- DATA_WID, 16, operand/immediate/data width.
- REG_ADDR_WID, 4, register address width.
- CNT_WID, 16, forward-hit counter width.
- ZERO_REG_EN, 0, 1 = register address 0 is never forwarded (always reads as register-file value).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active low.
- in_valid  in  1  ID stage presents a valid instruction.
- stall  in  1  hold all stage registers.
- flush  in  1  insert bubble.
- alu_src  in  3  operand select code.
- addr_a  in  REG_ADDR_WID  source register A address.
- addr_b  in  REG_ADDR_WID  source register B address.
- read_data_A  in  DATA_WID  register file port A.
- read_data_B  in  DATA_WID  register file port B.
- immediate  in  DATA_WID  extended immediate.
- fwd_ex_en / fwd_ex_addr / fwd_ex_data  in  1 / REG_ADDR_WID / DATA_WID  EX/MEM write-back forward.
- fwd_mem_en / fwd_mem_addr / fwd_mem_data  in  1 / REG_ADDR_WID / DATA_WID  MEM/WB write-back forward.
- out_valid  out  1  EX stage holds a valid instruction.
- srcdata_a  out  DATA_WID  ALU operand A.
- srcdata_b  out  DATA_WID  ALU operand B.
- memdata  out  DATA_WID  store data (forwarded register B).
- illegal_src  out  1  registered: captured alu_src was reserved.
- fwd_hits  out  CNT_WID  saturating count of forwarded operands.

Behaviour:
- Reset (rst low, async): all outputs 0.
- Forward resolve, per operand X in {A,B}, combinational: EX match (fwd_ex_en & fwd_ex_addr==addr_X) wins; else MEM match; else read_data_X. With ZERO_REG_EN=1 and addr_X==0, no forwarding.
- Codes (fa/fb = resolved A/B): 000 0/0; 001 fa/fb; 010 fa/imm; 011 fa/0; 100 imm/0; 101 fb/fa; 110 fb/imm; 111 reserved -> 0/0 and illegal_src=1 when captured.
- memdata = fb regardless of alu_src.
- Register update priority per rising edge: flush > stall > load.
  - flush: out_valid=0, srcdata_a/b, memdata, illegal_src = 0; counter unchanged. Flush overrides a simultaneous stall.
  - stall (no flush): all registers hold, counter holds.
  - otherwise: out_valid<=in_valid; if in_valid, capture operands/memdata/illegal_src; if !in_valid, operands, memdata and illegal_src <= 0.
- Latency: 1 cycle ID->EX.
- Counter: on a load cycle with in_valid, adds the number of operands actually consumed through a forward path (0, 1 or 2). Operand A is consumed for codes 001, 010, 011, 101; operand B for 001, 101, 110, and for store data in all codes. Each operand counts at most once. Saturates at all-ones; no wrap.
- Both forward paths matching the same address: EX data used; counts as one hit.
- Reset mid-stall or mid-flush: immediate clear; first edge after release behaves as a normal load.

Test Plan:
- Reset: rst low with random inputs -> all outputs 0; rst high, in_valid=1, alu_src=001, A=0x1234, B=0xABCD, no forwards -> next edge srcdata_a=0x1234, srcdata_b=0xABCD, memdata=0xABCD, out_valid=1.
- Forward priority: addr_a=3, both paths target r3 (EX data 0x5555, MEM data 0x6666), code 001 -> srcdata_a=0x5555; EX disabled -> 0x6666; fwd_hits increments by 1 each cycle.
- Swap and immediate: code 101, A=0x0001, B=0x0002 -> a=0x0002, b=0x0001; code 110, imm=0xFFF0 -> a=0x0002, b=0xFFF0, memdata=0x0002.
- Stall/flush: load code 010 (a=0x0011, b=0x0022), then stall for 3 cycles with new inputs -> outputs unchanged; flush with stall also high -> out_valid=0, all data 0.
- Reserved/zero reg: code 111 -> a=b=0, illegal_src=1. ZERO_REG_EN=1, addr_a=0, EX forward to r0 -> register-file value used, no count.
- Saturation: CNT_WID=4, 10 cycles of double forwards on code 001 -> fwd_hits stops at 15.

Source files
------------

// File: rtl/alu_operand_stage_if.sv
// ID->EX operand bundle: instruction and forwarding inputs from decode, registered ALU operands out.
interface alu_operand_stage_if #(
   parameter int DATA_WID     = 16,
   parameter int REG_ADDR_WID = 4,
   parameter int CNT_WID      = 16
);
   logic                    in_valid;
   logic                    stall;
   logic                    flush;
   logic [2:0]              alu_src;
   logic [REG_ADDR_WID-1:0] addr_a;
   logic [REG_ADDR_WID-1:0] addr_b;
   logic [DATA_WID-1:0]     read_data_A;
   logic [DATA_WID-1:0]     read_data_B;
   logic [DATA_WID-1:0]     immediate;
   logic                    fwd_ex_en;
   logic [REG_ADDR_WID-1:0] fwd_ex_addr;
   logic [DATA_WID-1:0]     fwd_ex_data;
   logic                    fwd_mem_en;
   logic [REG_ADDR_WID-1:0] fwd_mem_addr;
   logic [DATA_WID-1:0]     fwd_mem_data;
   logic                    out_valid;
   logic [DATA_WID-1:0]     srcdata_a;
   logic [DATA_WID-1:0]     srcdata_b;
   logic [DATA_WID-1:0]     memdata;
   logic                    illegal_src;
   logic [CNT_WID-1:0]      fwd_hits;

   modport master (
      output in_valid, stall, flush, alu_src, addr_a, addr_b,
             read_data_A, read_data_B, immediate,
             fwd_ex_en, fwd_ex_addr, fwd_ex_data,
             fwd_mem_en, fwd_mem_addr, fwd_mem_data,
      input  out_valid, srcdata_a, srcdata_b, memdata, illegal_src, fwd_hits
   );

   modport slave (
      input  in_valid, stall, flush, alu_src, addr_a, addr_b,
             read_data_A, read_data_B, immediate,
             fwd_ex_en, fwd_ex_addr, fwd_ex_data,
             fwd_mem_en, fwd_mem_addr, fwd_mem_data,
      output out_valid, srcdata_a, srcdata_b, memdata, illegal_src, fwd_hits
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ID/EX operand select: resolves forwarding, applies alu_src and registers
// ALU operands and store data; counts forwarded operands for performance debug.
module alu_operand_stage #(
   parameter int DATA_WID     = 16,
   parameter int REG_ADDR_WID = 4,
   parameter int CNT_WID      = 16,
   parameter int ZERO_REG_EN  = 0
) (
   input logic                clk,
   input logic                rst,
   alu_operand_stage_if.slave bus
);

   localparam logic [2:0] SRC_ZERO   = 3'b000;
   localparam logic [2:0] SRC_AB     = 3'b001;
   localparam logic [2:0] SRC_AIMM   = 3'b010;
   localparam logic [2:0] SRC_A0     = 3'b011;
   localparam logic [2:0] SRC_IMM0   = 3'b100;
   localparam logic [2:0] SRC_BA     = 3'b101;
   localparam logic [2:0] SRC_BIMM   = 3'b110;

   function automatic logic [CNT_WID-1:0] sat_add(input logic [CNT_WID-1:0] cnt,
                                                   input logic [1:0]         inc);
      logic [CNT_WID:0] sum;
      sum = {1'b0, cnt} + {{(CNT_WID-1){1'b0}}, inc};
      return sum[CNT_WID] ? {CNT_WID{1'b1}} : sum[CNT_WID-1:0];
   endfunction

   logic                zero_a_p0, zero_b_p0;
   logic                ex_a_p0, ex_b_p0, mem_a_p0, mem_b_p0;
   logic                hit_a_p0, hit_b_p0, use_a_p0;
   logic [DATA_WID-1:0] fa_p0, fb_p0;
   logic [DATA_WID-1:0] op_a_p0, op_b_p0;
   logic                ill_p0;
   logic [1:0]          inc_p0;

   logic                vld_p1;
   logic [DATA_WID-1:0] op_a_p1, op_b_p1, mem_p1;
   logic                ill_p1;
   logic [CNT_WID-1:0]  hits_p1;

   // ---- p0: forward resolve and operand select (combinational, ID side)
   always_comb begin
      zero_a_p0 = (ZERO_REG_EN != 0) && (bus.addr_a == '0);
      zero_b_p0 = (ZERO_REG_EN != 0) && (bus.addr_b == '0);
      ex_a_p0   = bus.fwd_ex_en  && (bus.fwd_ex_addr  == bus.addr_a) && !zero_a_p0;
      ex_b_p0   = bus.fwd_ex_en  && (bus.fwd_ex_addr  == bus.addr_b) && !zero_b_p0;
      mem_a_p0  = bus.fwd_mem_en && (bus.fwd_mem_addr == bus.addr_a) && !zero_a_p0;
      mem_b_p0  = bus.fwd_mem_en && (bus.fwd_mem_addr == bus.addr_b) && !zero_b_p0;
      // EX/MEM holds the younger result, so it wins over MEM/WB
      fa_p0     = ex_a_p0 ? bus.fwd_ex_data : (mem_a_p0 ? bus.fwd_mem_data : bus.read_data_A);
      fb_p0     = ex_b_p0 ? bus.fwd_ex_data : (mem_b_p0 ? bus.fwd_mem_data : bus.read_data_B);
      hit_a_p0  = ex_a_p0 || mem_a_p0;
      hit_b_p0  = ex_b_p0 || mem_b_p0;

      op_a_p0   = '0;
      op_b_p0   = '0;
      ill_p0    = 1'b0;
      use_a_p0  = 1'b0;
      case (bus.alu_src)
         SRC_ZERO: ;
         SRC_AB:   begin op_a_p0 = fa_p0;         op_b_p0 = fb_p0;         use_a_p0 = 1'b1; end
         SRC_AIMM: begin op_a_p0 = fa_p0;         op_b_p0 = bus.immediate; use_a_p0 = 1'b1; end
         SRC_A0:   begin op_a_p0 = fa_p0;                                  use_a_p0 = 1'b1; end
         SRC_IMM0: begin op_a_p0 = bus.immediate;                                           end
         SRC_BA:   begin op_a_p0 = fb_p0;         op_b_p0 = fa_p0;         use_a_p0 = 1'b1; end
         SRC_BIMM: begin op_a_p0 = fb_p0;         op_b_p0 = bus.immediate;                  end
         default:  ill_p0 = 1'b1;
      endcase

      // store data always consumes B, so a forwarded B counts in every code
      inc_p0 = {1'b0, hit_a_p0 && use_a_p0} + {1'b0, hit_b_p0};
   end

   // ---- p1: ID/EX registers (flush > stall > load)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         op_a_p1 <= '0;
         op_b_p1 <= '0;
         mem_p1  <= '0;
         ill_p1  <= 1'b0;
         hits_p1 <= '0;
      end else if (bus.flush) begin
         vld_p1  <= 1'b0;
         op_a_p1 <= '0;
         op_b_p1 <= '0;
         mem_p1  <= '0;
         ill_p1  <= 1'b0;
      end else if (!bus.stall) begin
         vld_p1 <= bus.in_valid;
         if (bus.in_valid) begin
            op_a_p1 <= op_a_p0;
            op_b_p1 <= op_b_p0;
            mem_p1  <= fb_p0;
            ill_p1  <= ill_p0;
            hits_p1 <= sat_add(hits_p1, inc_p0);
         end else begin
            op_a_p1 <= '0;
            op_b_p1 <= '0;
            mem_p1  <= '0;
            ill_p1  <= 1'b0;
         end
      end
   end

   assign bus.out_valid   = vld_p1;
   assign bus.srcdata_a   = op_a_p1;
   assign bus.srcdata_b   = op_b_p1;
   assign bus.memdata     = mem_p1;
   assign bus.illegal_src = ill_p1;
   assign bus.fwd_hits    = hits_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: a default instance and a CNT_WID=4, ZERO_REG_EN=1 instance.
module tb_alu_operand_stage;

   typedef struct {
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] m;
      logic        ill;
      int unsigned h;
   } exp_t;

   logic clk;
   logic rst;
   logic        in_valid, stall, flush;
   logic [2:0]  alu_src;
   logic [3:0]  addr_a, addr_b, fwd_ex_addr, fwd_mem_addr;
   logic [15:0] rd_a, rd_b, imm, fwd_ex_data, fwd_mem_data;
   logic        fwd_ex_en, fwd_mem_en;

   int n_chk;
   int n_pass;
   exp_t m0, m1, e0, e1;
   exp_t q0[$];
   exp_t q1[$];

   alu_operand_stage_if #(.DATA_WID(16), .REG_ADDR_WID(4), .CNT_WID(16)) if0 ();
   alu_operand_stage_if #(.DATA_WID(16), .REG_ADDR_WID(4), .CNT_WID(4))  if1 ();

   alu_operand_stage #(.DATA_WID(16), .REG_ADDR_WID(4), .CNT_WID(16), .ZERO_REG_EN(0)) dut0 (
      .clk(clk), .rst(rst), .bus(if0));
   alu_operand_stage #(.DATA_WID(16), .REG_ADDR_WID(4), .CNT_WID(4), .ZERO_REG_EN(1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1));

   assign if0.in_valid = in_valid;      assign if1.in_valid = in_valid;
   assign if0.stall = stall;            assign if1.stall = stall;
   assign if0.flush = flush;            assign if1.flush = flush;
   assign if0.alu_src = alu_src;        assign if1.alu_src = alu_src;
   assign if0.addr_a = addr_a;          assign if1.addr_a = addr_a;
   assign if0.addr_b = addr_b;          assign if1.addr_b = addr_b;
   assign if0.read_data_A = rd_a;       assign if1.read_data_A = rd_a;
   assign if0.read_data_B = rd_b;       assign if1.read_data_B = rd_b;
   assign if0.immediate = imm;          assign if1.immediate = imm;
   assign if0.fwd_ex_en = fwd_ex_en;    assign if1.fwd_ex_en = fwd_ex_en;
   assign if0.fwd_ex_addr = fwd_ex_addr;   assign if1.fwd_ex_addr = fwd_ex_addr;
   assign if0.fwd_ex_data = fwd_ex_data;   assign if1.fwd_ex_data = fwd_ex_data;
   assign if0.fwd_mem_en = fwd_mem_en;     assign if1.fwd_mem_en = fwd_mem_en;
   assign if0.fwd_mem_addr = fwd_mem_addr; assign if1.fwd_mem_addr = fwd_mem_addr;
   assign if0.fwd_mem_data = fwd_mem_data; assign if1.fwd_mem_data = fwd_mem_data;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
   endtask

   function automatic exp_t zero_state();
      exp_t z;
      z.v = 1'b0; z.a = '0; z.b = '0; z.m = '0; z.ill = 1'b0; z.h = 0;
      return z;
   endfunction

   // returns {forwarded, value} for one source operand
   function automatic logic [16:0] resolve(input logic [3:0] addr, input logic [15:0] rd,
                                           input bit zero_en);
      if (zero_en && addr == 4'd0) return {1'b0, rd};
      if (fwd_ex_en && fwd_ex_addr == addr) return {1'b1, fwd_ex_data};
      if (fwd_mem_en && fwd_mem_addr == addr) return {1'b1, fwd_mem_data};
      return {1'b0, rd};
   endfunction

   function automatic exp_t next_state(input exp_t cur, input bit zero_en, input int unsigned cmax);
      exp_t n;
      logic [16:0] ra, rb;
      int unsigned inc;
      bit use_a;
      n = cur;
      if (flush) begin
         n.v = 1'b0; n.a = '0; n.b = '0; n.m = '0; n.ill = 1'b0;
         return n;
      end
      if (stall) return n;
      n.v = in_valid;
      if (!in_valid) begin
         n.a = '0; n.b = '0; n.m = '0; n.ill = 1'b0;
         return n;
      end
      ra = resolve(addr_a, rd_a, zero_en);
      rb = resolve(addr_b, rd_b, zero_en);
      n.ill = 1'b0;
      use_a = (alu_src == 3'd1) || (alu_src == 3'd2) || (alu_src == 3'd3) || (alu_src == 3'd5);
      case (alu_src)
         3'd1: begin n.a = ra[15:0]; n.b = rb[15:0]; end
         3'd2: begin n.a = ra[15:0]; n.b = imm;      end
         3'd3: begin n.a = ra[15:0]; n.b = 16'h0;    end
         3'd4: begin n.a = imm;      n.b = 16'h0;    end
         3'd5: begin n.a = rb[15:0]; n.b = ra[15:0]; end
         3'd6: begin n.a = rb[15:0]; n.b = imm;      end
         3'd7: begin n.a = 16'h0;    n.b = 16'h0;    n.ill = 1'b1; end
         default: begin n.a = 16'h0; n.b = 16'h0;    end
      endcase
      n.m = rb[15:0];
      inc = (rb[16] ? 1 : 0) + ((use_a && ra[16]) ? 1 : 0);
      n.h = (cur.h + inc > cmax) ? cmax : cur.h + inc;
      return n;
   endfunction

   task automatic check_out(input string tag, input exp_t e, input logic v,
                            input logic [15:0] a, input logic [15:0] b, input logic [15:0] m,
                            input logic ill, input logic [31:0] h);
      chk({tag, ".out_valid"}, 32'(v), 32'(e.v));
      chk({tag, ".srcdata_a"}, 32'(a), 32'(e.a));
      chk({tag, ".srcdata_b"}, 32'(b), 32'(e.b));
      chk({tag, ".memdata"}, 32'(m), 32'(e.m));
      chk({tag, ".illegal_src"}, 32'(ill), 32'(e.ill));
      chk({tag, ".fwd_hits"}, h, e.h);
   endtask

   task automatic cycle();
      m0 = next_state(m0, 1'b0, 32'd65535);
      m1 = next_state(m1, 1'b1, 32'd15);
      q0.push_back(m0);
      q1.push_back(m1);
      @(posedge clk);
      #1;
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      check_out("d0", e0, if0.out_valid, if0.srcdata_a, if0.srcdata_b, if0.memdata,
                if0.illegal_src, 32'(if0.fwd_hits));
      check_out("d1", e1, if1.out_valid, if1.srcdata_a, if1.srcdata_b, if1.memdata,
                if1.illegal_src, 32'(if1.fwd_hits));
   endtask

   task automatic reset_check(input string tag);
      rst = 1'b0;
      #2;
      m0 = zero_state();
      m1 = zero_state();
      q0.delete();
      q1.delete();
      check_out({tag, ".d0"}, m0, if0.out_valid, if0.srcdata_a, if0.srcdata_b, if0.memdata,
                if0.illegal_src, 32'(if0.fwd_hits));
      check_out({tag, ".d1"}, m1, if1.out_valid, if1.srcdata_a, if1.srcdata_b, if1.memdata,
                if1.illegal_src, 32'(if1.fwd_hits));
      rst = 1'b1;
   endtask

   task automatic rand_inputs(input int unsigned amax);
      in_valid     = 1'($urandom_range(0, 3) != 0);
      stall        = 1'($urandom_range(0, 4) == 0);
      flush        = 1'($urandom_range(0, 7) == 0);
      alu_src      = 3'($urandom_range(0, 7));
      addr_a       = 4'($urandom_range(0, amax));
      addr_b       = 4'($urandom_range(0, amax));
      rd_a         = 16'($urandom);
      rd_b         = 16'($urandom);
      imm          = 16'($urandom);
      fwd_ex_en    = 1'($urandom_range(0, 1));
      fwd_ex_addr  = 4'($urandom_range(0, amax));
      fwd_ex_data  = 16'($urandom);
      fwd_mem_en   = 1'($urandom_range(0, 1));
      fwd_mem_addr = 4'($urandom_range(0, amax));
      fwd_mem_data = 16'($urandom);
   endtask

   task automatic quiet(input logic [2:0] src, input logic [15:0] a, input logic [15:0] b);
      in_valid = 1'b1; stall = 1'b0; flush = 1'b0; alu_src = src;
      addr_a = 4'd1; addr_b = 4'd2; rd_a = a; rd_b = b; imm = 16'h0;
      fwd_ex_en = 1'b0; fwd_ex_addr = 4'd0; fwd_ex_data = 16'h0;
      fwd_mem_en = 1'b0; fwd_mem_addr = 4'd0; fwd_mem_data = 16'h0;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst = 1'b0;
      rand_inputs(15);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_check("rst");

      // first load after reset
      quiet(3'b001, 16'h1234, 16'hABCD);
      cycle();
      chk("load.a", 32'(if0.srcdata_a), 32'h1234);
      chk("load.m", 32'(if0.memdata), 32'hABCD);

      // both forward paths on r3: EX wins, then MEM alone
      quiet(3'b001, 16'h0101, 16'h0202);
      addr_a = 4'd3; addr_b = 4'd5;
      fwd_ex_en = 1'b1;  fwd_ex_addr = 4'd3;  fwd_ex_data = 16'h5555;
      fwd_mem_en = 1'b1; fwd_mem_addr = 4'd3; fwd_mem_data = 16'h6666;
      cycle();
      chk("fwd.ex", 32'(if0.srcdata_a), 32'h5555);
      chk("fwd.hits1", 32'(if0.fwd_hits), 32'd1);
      fwd_ex_en = 1'b0;
      cycle();
      chk("fwd.mem", 32'(if0.srcdata_a), 32'h6666);
      chk("fwd.hits2", 32'(if0.fwd_hits), 32'd2);

      // swap and immediate
      quiet(3'b101, 16'h0001, 16'h0002);
      cycle();
      quiet(3'b110, 16'h0001, 16'h0002);
      imm = 16'hFFF0;
      cycle();
      chk("bimm.b", 32'(if0.srcdata_b), 32'hFFF0);

      // stall holds, flush beats stall
      quiet(3'b010, 16'h0011, 16'h0099);
      imm = 16'h0022;
      cycle();
      for (int i = 0; i < 3; i++) begin
         rand_inputs(15);
         stall = 1'b1;
         flush = 1'b0;
         cycle();
      end
      chk("stall.a", 32'(if0.srcdata_a), 32'h0011);
      flush = 1'b1;
      stall = 1'b1;
      cycle();

      // reserved code and zero register
      quiet(3'b111, 16'h7777, 16'h8888);
      cycle();
      chk("rsv.ill", 32'(if0.illegal_src), 32'd1);
      quiet(3'b001, 16'h0A0A, 16'h0B0B);
      addr_a = 4'd0; addr_b = 4'd2;
      fwd_ex_en = 1'b1; fwd_ex_addr = 4'd0; fwd_ex_data = 16'hBEEF;
      cycle();
      chk("zr.d1a", 32'(if1.srcdata_a), 32'h0A0A);
      chk("zr.d0a", 32'(if0.srcdata_a), 32'hBEEF);
      in_valid = 1'b0;
      cycle();

      // saturation on the 4-bit counter
      quiet(3'b001, 16'h1111, 16'h2222);
      addr_a = 4'd4; addr_b = 4'd6;
      fwd_ex_en = 1'b1;  fwd_ex_addr = 4'd4;  fwd_ex_data = 16'h4444;
      fwd_mem_en = 1'b1; fwd_mem_addr = 4'd6; fwd_mem_data = 16'h6666;
      for (int i = 0; i < 10; i++) cycle();
      chk("sat.d1", 32'(if1.fwd_hits), 32'd15);

      // async reset during stall and during flush, then a normal load
      stall = 1'b1;
      cycle();
      reset_check("rst_stall");
      stall = 1'b0;
      quiet(3'b011, 16'h3C3C, 16'h4D4D);
      cycle();
      flush = 1'b1;
      cycle();
      reset_check("rst_flush");
      quiet(3'b100, 16'h1357, 16'h2468);
      imm = 16'h8001;
      cycle();

      for (int i = 0; i < 60; i++) begin
         rand_inputs(3);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
